mac_shift_stage: RTL and testbench
==================================

MAC_SHIFT_STAGE -- requirements
Module: mac_shift_stage

Interface
REQ-001 SHALL have parameter DW, default 16: signed sample width.
REQ-002 SHALL have parameter CW, default 16: signed coefficient width.
REQ-003 SHALL have parameter ACCW, default 40: accumulator width; constraint ACCW >= DW+CW.
REQ-004 SHALL have parameter SHIFT, default 8: arithmetic right-shift applied to the final sum; constraint 0 <= SHIFT < ACCW.
REQ-005 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port inValid  in  1  input beat present.
REQ-008 SHALL have port inReady  out  1  input beat accepted at this edge if inValid is also high.
REQ-009 SHALL have port inSample  in  DW  signed sample.
REQ-010 SHALL have port inCoef  in  CW  signed coefficient.
REQ-011 SHALL have port inLast  in  1  marks the final beat of a packet.
REQ-012 SHALL have port outValid  out  1  result present.
REQ-013 SHALL have port outReady  in  1  consumer takes the result at this edge.
REQ-014 SHALL have port outValue  out  ACCW-SHIFT  signed shifted sum; the parent feeds it to the saturating clamp.
REQ-015 SHALL have port outTerms  out  8  number of beats in the packet, saturating at 255.

Function
REQ-016 SHALL compute inReady combinationally as NOT (outValid AND NOT outReady).
- Any output backpressure freezes the whole pipeline.
REQ-017 SHALL register the product, stage P: inSample*inCoef, signed, DW+CW bits, plus prodValid and prodLast.
- Stage P loads only when inReady is high.
- prodValid = inValid when stage P loads.
REQ-018 SHALL update the accumulator, stage A, when prodValid is high and the pipeline is not frozen.
- First beat of a packet: acc = sign-extended product.
- Later beats: acc = acc + product, wrapping modulo 2^ACCW.
- No saturation inside this block.
REQ-019 SHALL count beats per packet in termCnt, saturating at 255; never wraps.
REQ-020 SHALL, when stage A consumes a prodLast beat:
- load outValue = (acc_next >>> SHIFT), arithmetic shift, floor rounding;
- load outTerms = termCnt_next;
- set outValid = 1;
- clear acc and termCnt and mark the next beat as first.
REQ-021 SHALL have latency 2: the last beat accepted at edge t gives outValid high after edge t+2, when outReady was high throughout.
REQ-022 SHALL hold outValue and outTerms stable while outValid is high and outReady is low.
REQ-023 SHALL clear outValid at an edge with outValid AND outReady, unless a new result loads at that same edge; then outValid stays 1 and the new values appear.
REQ-024 SHALL accept single-beat packets (inLast on the first beat) and back-to-back packets with no idle cycle, sustaining one result per cycle.
REQ-025 SHALL ignore inSample, inCoef and inLast when inValid is low; the pipeline inserts bubbles without disturbing acc.

Reset
REQ-026 SHALL, while rst is high at an edge, clear prodValid, prodLast, acc, termCnt, outValid, outValue and outTerms to 0, and set the first-beat flag.
REQ-027 SHALL discard any partial packet on reset mid-operation; the next accepted beat starts a new packet.
REQ-028 SHALL give inReady = 1 in the first cycle after reset.

Structure
REQ-029 SHALL take the default parameter constants (DW, CW, ACCW, SHIFT) and the term-counter width from the shared package mac_pkg.
REQ-030 SHALL be a single module with no sub-module; the multiplier is inferred.
- The clamp and rounding stages are instantiated by the parent, downstream of outValue.

Verification
REQ-031 SHALL cover a 3-beat sum: samples (100,-200,300), coefs (2,3,-1), SHIFT=8 -> outValue = -3 (floor of -700/256), outTerms = 3.
REQ-032 SHALL cover a single-beat extreme: 32767*32767 with inLast -> outValue = 4194048, outTerms = 1, outValid at t+2.
REQ-033 SHALL cover backpressure: outReady=0 for 5 cycles while outValid is high -> inReady=0, outValue unchanged all 5 cycles; a queued second packet (1*256) then yields 1 right after release.
REQ-034 SHALL cover reset mid-packet: 2 of 3 beats sent, rst high 1 cycle, then single beat 1*256 -> outValue = 1, outTerms = 1, no residue.
REQ-035 SHALL cover wrap and count saturation: 600 beats of (-32768)*(-32768) -> outValue = -1778384896, outTerms = 255.
REQ-036 SHALL cover streaming: 10 back-to-back single-beat packets k*256 (k=1..10) with outReady=1 -> outValue 1..10 on 10 consecutive cycles.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants for the multiply-accumulate datapath: default widths, the
// output shift and the per-packet term counter.
package mac_pkg;

  localparam int unsigned DefDw    = 16;
  localparam int unsigned DefCw    = 16;
  localparam int unsigned DefAccw  = 40;
  localparam int unsigned DefShift = 8;
  localparam int unsigned TermW    = 8;

  localparam logic [TermW-1:0] TermMax = '1;

  // Saturating increment: the term count sticks at its maximum, never wraps.
  function automatic logic [TermW-1:0] term_inc(input logic [TermW-1:0] cnt);
    return (cnt == TermMax) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/mac_shift_stage.sv
// Two-stage packetised multiply-accumulate: register the product, accumulate per
// packet, then present the arithmetically right-shifted sum with its term count.
module mac_shift_stage
  import mac_pkg::*;
#(
  parameter int unsigned DW    = DefDw,
  parameter int unsigned CW    = DefCw,
  parameter int unsigned ACCW  = DefAccw,
  parameter int unsigned SHIFT = DefShift
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic signed [DW-1:0]         inSample,
  input  logic signed [CW-1:0]         inCoef,
  input  logic                         inLast,
  output logic                         outValid,
  input  logic                         outReady,
  output logic signed [ACCW-SHIFT-1:0] outValue,
  output logic [TermW-1:0]             outTerms
);

  localparam int unsigned PW = DW + CW;

  logic signed [PW-1:0]         sample_ext, coef_ext;
  logic signed [PW-1:0]         prod_q;
  logic                         prod_valid_q, prod_last_q;
  logic                         first_q;
  logic signed [ACCW-1:0]       acc_q, acc_d;
  logic [TermW-1:0]             term_q, term_d;
  logic                         out_valid_q;
  logic signed [ACCW-SHIFT-1:0] out_value_q;
  logic [TermW-1:0]             out_terms_q;
  logic                         adv;

  // A result held against backpressure stalls every stage.
  assign inReady  = ~(out_valid_q & ~outReady);
  assign adv      = prod_valid_q & inReady;

  assign outValid = out_valid_q;
  assign outValue = out_value_q;
  assign outTerms = out_terms_q;

  always_comb begin
    sample_ext = PW'(inSample);
    coef_ext   = PW'(inCoef);
    acc_d      = first_q ? ACCW'(prod_q) : acc_q + ACCW'(prod_q);
    term_d     = term_inc(term_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      prod_last_q  <= 1'b0;
      acc_q        <= '0;
      term_q       <= '0;
      first_q      <= 1'b1;
      out_valid_q  <= 1'b0;
      out_value_q  <= '0;
      out_terms_q  <= '0;
    end else begin
      if (inReady) begin
        prod_q       <= sample_ext * coef_ext;
        prod_valid_q <= inValid;
        prod_last_q  <= inLast;
      end

      if (adv && prod_last_q) begin
        // Upper slice of the sum is the floor-rounded arithmetic shift.
        out_value_q <= acc_d[ACCW-1:SHIFT];
        out_terms_q <= term_d;
        out_valid_q <= 1'b1;
        acc_q       <= '0;
        term_q      <= '0;
        first_q     <= 1'b1;
      end else begin
        if (adv) begin
          acc_q   <= acc_d;
          term_q  <= term_d;
          first_q <= 1'b0;
        end
        if (out_valid_q && outReady) begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_shift_stage.sv
// Randomised and directed bench for mac_shift_stage against a packet-level
// arithmetic model of the accumulate/shift/count behaviour.
module tb_mac_shift_stage;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready, in_last;
  logic signed [15:0] in_sample, in_coef;
  logic               out_valid, out_ready;
  logic signed [31:0] out_value;
  logic [7:0]         out_terms;

  mac_shift_stage dut (
    .clk      (clk),
    .rst      (rst),
    .inValid  (in_valid),
    .inReady  (in_ready),
    .inSample (in_sample),
    .inCoef   (in_coef),
    .inLast   (in_last),
    .outValid (out_valid),
    .outReady (out_ready),
    .outValue (out_value),
    .outTerms (out_terms)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit checking = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: one product in flight, the packet sum kept as an unbounded integer
  // and wrapped to 40 bits only when the packet closes.
  bit     p_v, p_l;
  longint p_prod;
  longint m_sum;
  int     m_cnt;
  bit     m_ov;
  longint m_val;
  int     m_terms;

  function automatic longint wrap40(input longint s);
    longint w;
    w = s & ((64'sd1 <<< 40) - 1);
    if (w >= (64'sd1 <<< 39)) w -= (64'sd1 <<< 40);
    return w;
  endfunction

  function automatic longint floor_div256(input longint w);
    return (w - (((w % 256) + 256) % 256)) / 256;
  endfunction

  task automatic model_step();
    bit ready, loaded;
    if (rst) begin
      p_v = 0; p_l = 0; p_prod = 0; m_sum = 0; m_cnt = 0;
      m_ov = 0; m_val = 0; m_terms = 0;
    end else begin
      ready  = !(m_ov && !out_ready);
      loaded = 0;
      if (ready) begin
        if (p_v) begin
          m_sum += p_prod;
          m_cnt++;
          if (p_l) begin
            m_val   = floor_div256(wrap40(m_sum));
            m_terms = (m_cnt > 255) ? 255 : m_cnt;
            m_ov    = 1;
            loaded  = 1;
            m_sum   = 0;
            m_cnt   = 0;
          end
        end
        p_v    = in_valid;
        p_l    = in_last;
        p_prod = longint'(in_sample) * longint'(in_coef);
      end
      if (!loaded && m_ov && out_ready) m_ov = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  typedef struct {longint v; int t; int c;} obs_t;
  obs_t obs[$];

  initial forever begin
    @(negedge clk);
    if (checking) begin
      chk("inReady", in_ready, !(m_ov && !out_ready));
      chk("outValid", out_valid, m_ov);
      if (m_ov) begin
        chk("outValue", out_value, m_val);
        chk("outTerms", out_terms, m_terms);
      end
      if (out_valid && out_ready) obs.push_back('{v: out_value, t: out_terms, c: cyc});
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat and hold it until an edge accepts it; inputs stay driven.
  task automatic send(input int s, input int c, input bit last);
    bit got;
    int k;
    in_valid  = 1'b1;
    in_sample = 16'(s);
    in_coef   = 16'(c);
    in_last   = last;
    k = 0;
    do begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      k++;
    end while (!got && k < 100);
    if (!got) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_obs(input string name, input int n);
    int k;
    k = 0;
    while (obs.size() < n && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(name, obs.size() >= n, 1);
  endtask

  initial begin
    int drive_cyc;
    int k;
    rst = 1'b1; in_valid = 0; in_last = 0; in_sample = 0; in_coef = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checking = 1'b1;
    @(negedge clk);
    chk("reset_inReady", in_ready, 1);
    chk("reset_outValid", out_valid, 0);
    chk("reset_outValue", out_value, 0);
    chk("reset_outTerms", out_terms, 0);
    @(posedge clk);
    #1;

    // Three-beat sum: -700 floors to -3.
    obs.delete();
    send(100, 2, 0); send(-200, 3, 0); send(300, -1, 1);
    in_valid = 0;
    wait_obs("sum3_done", 1);
    if (obs.size() >= 1) begin
      chk("sum3_value", obs[0].v, -3);
      chk("sum3_terms", obs[0].t, 3);
    end
    idle(3);

    // Single extreme beat, driven in cycle t, visible after edge t+2.
    obs.delete();
    drive_cyc = cyc;
    send(32767, 32767, 1);
    in_valid = 0;
    wait_obs("ext_done", 1);
    if (obs.size() >= 1) begin
      chk("ext_value", obs[0].v, 4194048);
      chk("ext_terms", obs[0].t, 1);
      chk("ext_latency", obs[0].c, drive_cyc + 2);
    end
    idle(3);

    // Backpressure with a second packet queued behind the held result.
    obs.delete();
    out_ready = 0;
    send(5, 256, 1); send(1, 256, 1);
    in_valid = 0;
    k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("bp_valid_seen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_inReady", in_ready, 0);
      chk("bp_hold_value", out_value, 5);
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    wait_obs("bp_done", 2);
    if (obs.size() >= 2) begin
      chk("bp_first", obs[0].v, 5);
      chk("bp_second", obs[1].v, 1);
      chk("bp_back_to_back", obs[1].c, obs[0].c + 1);
    end
    idle(3);

    // Reset drops a partial packet.
    send(1000, 1000, 0); send(7, 9, 0);
    in_valid = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    obs.delete();
    send(1, 256, 1);
    in_valid = 0;
    wait_obs("rst_done", 1);
    if (obs.size() >= 1) begin
      chk("rst_value", obs[0].v, 1);
      chk("rst_terms", obs[0].t, 1);
    end
    idle(3);

    // 600 max-magnitude products: 40-bit wrap and term saturation.
    obs.delete();
    for (int i = 0; i < 600; i++) send(-32768, -32768, i == 599);
    in_valid = 0;
    wait_obs("wrap_done", 1);
    if (obs.size() >= 1) begin
      chk("wrap_value", obs[0].v, -1778384896);
      chk("wrap_terms", obs[0].t, 255);
    end
    idle(3);

    // Streaming single-beat packets, one result per cycle.
    obs.delete();
    for (int i = 1; i <= 10; i++) send(i, 256, 1);
    in_valid = 0;
    wait_obs("stream_done", 10);
    if (obs.size() >= 10) begin
      for (int i = 0; i < 10; i++) begin
        chk("stream_value", obs[i].v, i + 1);
        if (i > 0) chk("stream_cycle", obs[i].c, obs[i-1].c + 1);
      end
    end
    idle(3);

    // Random traffic with random backpressure, checked by the model every cycle.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_sample = 16'($urandom);
      in_coef   = 16'($urandom);
      in_last   = ($urandom_range(3) == 0);
      out_ready = ($urandom_range(2) != 0);
      if (i == 700) rst = 1;
      else rst = 0;
      @(posedge clk);
      #1;
    end
    rst = 0;
    in_valid = 0;
    out_ready = 1;
    idle(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
